// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Multi-cycle data-memory responder for the MEM stage. A request from EX/MEM
//   is captured in IDLE. It waits LAT_CYCLES cycles in BUSY and touches the
//   array on the last BUSY edge. It then retires in DONE with a one-cycle
//   mem_ready pulse. The pipeline is held with mem_stall until DONE.
//
//   Handshake: the EX/MEM request (mem_read/mem_write level plus mem_addr,
//   write_data) is sampled only in IDLE. mem_stall is high in that IDLE cycle
//   and through all of BUSY. mem_ready (and mem_err for illegal requests)
//   pulses for exactly one cycle in DONE, where mem_stall is low. The pipeline
//   therefore advances on the DONE edge and the retired request is never
//   resampled.
//
//   Optional feature macro: DMEM_SIZE_EN adds mem_size (func3 encoding) for
//   byte/half/word/double accesses with sign/zero extension and sub-word
//   read-modify-write stores. Without it, every access is a doubleword.
//
// Ports
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous, active-low reset
//   mem_addr   in   64  byte address (held stable while mem_stall=1)
//   write_data in   64  store data
//   mem_read   in   1   load request level
//   mem_write  in   1   store request level
//   mem_size   in   3   access size, only with DMEM_SIZE_EN
//   Read_data  out  64  registered load result, valid while mem_ready=1
//   mem_ready  out  1   one-cycle completion pulse
//   mem_stall  out  1   combinational pipeline hold
//   mem_err    out  1   one-cycle illegal-request pulse, aligned with mem_ready
//   dbg_state  out  2   FSM state (0=IDLE, 1=BUSY, 2=DONE)
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int LAT_CYCLES  = 3,
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] mem_addr,
  input  logic [63:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
`ifdef DMEM_SIZE_EN
  input  logic [2:0]  mem_size,
`endif
  output logic [63:0] Read_data,
  output logic        mem_ready,
  output logic        mem_stall,
  output logic        mem_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0]    cnt_q;
  logic [AW-1:0] idx_q;
  logic [63:0]   data_q;
  logic          wr_q;
  logic          err_q;
`ifdef DMEM_SIZE_EN
  logic [2:0]    off_q;
  logic [2:0]    size_q;
`endif

  logic [63:0] mem [DEPTH_WORDS];

  logic        req;
  logic        aligned;
  logic        in_range;
  logic        legal;
  logic        access;
  logic [63:0] cur_word;
  logic [63:0] load_val;
  logic [63:0] store_word;

  // ---------------- request qualification ----------------
  assign req      = mem_read | mem_write;
  assign in_range = (mem_addr[63:AW+3] == '0);

`ifdef DMEM_SIZE_EN
  always_comb begin
    aligned = 1'b0;
    case (mem_size)
      3'd0, 3'd4: aligned = 1'b1;
      3'd1, 3'd5: aligned = (mem_addr[0] == 1'b0);
      3'd2, 3'd6: aligned = (mem_addr[1:0] == 2'b00);
      3'd3:       aligned = (mem_addr[2:0] == 3'b000);
      default:    aligned = 1'b0;  // size 7 has no meaning
    endcase
  end
`else
  assign aligned = (mem_addr[2:0] == 3'b000);
`endif

  assign legal  = req & ~(mem_read & mem_write) & aligned & in_range;

  // The array is touched on the edge that leaves BUSY.
  assign access = (state_q == S_BUSY) && (cnt_q == 4'd0);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (legal)    state_d = S_BUSY;
        else if (req) state_d = S_DONE;
      end
      S_BUSY:  if (cnt_q == 4'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    mem_ready = (state_q == S_DONE);
    mem_err   = (state_q == S_DONE) & err_q;
    mem_stall = ((state_q == S_IDLE) & req) | (state_q == S_BUSY);
    dbg_state = state_q;
  end

  // ---------------- load/store data path ----------------
  assign cur_word = mem[idx_q];

`ifdef DMEM_SIZE_EN
  logic [5:0]  shamt;
  logic [63:0] field;
  logic [63:0] size_mask;
  logic [63:0] wmask;

  always_comb begin
    shamt = {off_q, 3'b000};
    field = cur_word >> shamt;
    size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    load_val  = field;
    case (size_q[1:0])
      2'd0: begin
        size_mask = 64'h0000_0000_0000_00FF;
        load_val  = size_q[2] ? {56'd0, field[7:0]} : {{56{field[7]}}, field[7:0]};
      end
      2'd1: begin
        size_mask = 64'h0000_0000_0000_FFFF;
        load_val  = size_q[2] ? {48'd0, field[15:0]} : {{48{field[15]}}, field[15:0]};
      end
      2'd2: begin
        size_mask = 64'h0000_0000_FFFF_FFFF;
        load_val  = size_q[2] ? {32'd0, field[31:0]} : {{32{field[31]}}, field[31:0]};
      end
      default: begin
        size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        load_val  = field;
      end
    endcase
    // Only the addressed bytes change; the rest of the doubleword is kept.
    wmask      = size_mask << shamt;
    store_word = (cur_word & ~wmask) | ((data_q << shamt) & wmask);
  end
`else
  assign load_val   = cur_word;
  assign store_word = data_q;
`endif

  // Capture registers, wait counter and registered load result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      data_q    <= 64'd0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      Read_data <= 64'd0;
`ifdef DMEM_SIZE_EN
      off_q     <= 3'd0;
      size_q    <= 3'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (legal) begin
            cnt_q  <= 4'(LAT_CYCLES - 1);
            idx_q  <= mem_addr[AW+2:3];
            data_q <= write_data;
            wr_q   <= mem_write;
            err_q  <= 1'b0;
`ifdef DMEM_SIZE_EN
            off_q  <= mem_addr[2:0];
            size_q <= mem_size;
`endif
          end else if (req) begin
            err_q     <= 1'b1;
            Read_data <= 64'd0;
          end
        end
        S_BUSY: begin
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
          else               Read_data <= wr_q ? 64'd0 : load_val;
        end
        default: ;
      endcase
    end
  end

  // Array has no reset; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (access && wr_q) mem[idx_q] <= store_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam int LAT   = 3;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] mem_addr;
  logic [63:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] Read_data;
  logic        mem_ready;
  logic        mem_stall;
  logic        mem_err;
  logic [1:0]  dbg_state;
`ifdef DMEM_SIZE_EN
  logic [2:0]  mem_size;
`endif

  always #5 clk = ~clk;

  dmem_responder #(.LAT_CYCLES(LAT), .DEPTH_WORDS(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
`ifdef DMEM_SIZE_EN
    .mem_size   (mem_size),
`endif
    .Read_data  (Read_data),
    .mem_ready  (mem_ready),
    .mem_stall  (mem_stall),
    .mem_err    (mem_err),
    .dbg_state  (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // Reference memory: one doubleword per index.
  logic [63:0] model_mem [DEPTH];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] data;
    logic        exp_err;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  // ---------------- scoreboard helpers ----------------
  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] init_val(input int i);
    return 64'hA5A5_0000_0000_0000 | (64'(i) * 64'h0000_0001_0001);
  endfunction

  // Reference rules: a request is legal when exactly one of read/write is set,
  // the address is doubleword aligned and it falls inside the array.
  function automatic logic model_legal(input logic rd, input logic wr, input logic [63:0] addr);
    return (rd != wr) && (addr % 8 == 0) && (addr < 64'(DEPTH * 8));
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge. Drives one request and checks latency,
  // stall length, the error flag, the data and the hold behaviour after DONE.
  // change_at >= 1 perturbs address and store data during BUSY.
  task automatic do_req(input logic rd, input logic wr, input logic [63:0] addr,
                        input logic [63:0] data, input int change_at,
                        input logic [63:0] alt_addr, input logic exp_err,
                        input logic [63:0] exp_rdata, input string tag);
    int   cyc;
    int   stalls;
    int   err_outside;
    int   lat;
    int   exp_lat;
    logic seen;
    mem_read    = rd;
    mem_write   = wr;
    mem_addr    = addr;
    write_data  = data;
    cyc         = 0;
    stalls      = 0;
    err_outside = 0;
    lat         = -1;
    seen        = 1'b0;
    exp_lat     = exp_err ? 1 : LAT + 1;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      if (mem_ready) begin
        seen = 1'b1;
        lat  = cyc;
        check1({tag, " stall_in_done"}, mem_stall, 1'b0);
        check1({tag, " err"}, mem_err, exp_err);
        check64({tag, " rdata"}, Read_data, exp_rdata);
      end else begin
        if (mem_stall) stalls++;
        if (mem_err) err_outside++;
        if (cyc == change_at) begin
          mem_addr   = alt_addr;
          write_data = ~data;
        end
      end
      cyc++;
    end
    check1({tag, " ready_seen"}, seen, 1'b1);
    check_int({tag, " latency"}, lat, exp_lat);
    check_int({tag, " stall_cycles"}, stalls, exp_lat);
    check_int({tag, " err_outside_done"}, err_outside, 0);
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check1({tag, " ready_one_cycle"}, mem_ready, 1'b0);
    check64({tag, " rdata_hold"}, Read_data, exp_rdata);
    @(posedge clk);
    #1;
  endtask

  // Model-driven operation: expectation from the reference rules, then model update.
  task automatic run_op(input logic rd, input logic wr, input logic [63:0] addr,
                        input logic [63:0] data, input int change_at,
                        input logic [63:0] alt_addr, input string tag);
    logic        lg;
    logic [63:0] exp_rd;
    lg     = model_legal(rd, wr, addr);
    exp_rd = (lg && rd) ? model_mem[addr / 8] : 64'd0;
    do_req(rd, wr, addr, data, change_at, alt_addr, !lg, exp_rd, tag);
    if (lg && wr) model_mem[addr / 8] = data;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = 64'd0;
    write_data = 64'd0;
`ifdef DMEM_SIZE_EN
    mem_size   = 3'd3;
`endif

    // Directed table; expectations follow from the preload init_val(i).
    vecs.push_back('{1'b0, 1'b1, 64'd16,  64'h1234_5678_9ABC_DEF0, 1'b0, 64'd0});
    vecs.push_back('{1'b1, 1'b0, 64'd16,  64'd0, 1'b0, 64'h1234_5678_9ABC_DEF0});
    vecs.push_back('{1'b0, 1'b1, 64'd24,  64'h777, 1'b0, 64'd0});
    vecs.push_back('{1'b1, 1'b0, 64'd12,  64'd0, 1'b1, 64'd0});
    vecs.push_back('{1'b0, 1'b1, 64'd12,  64'hFFFF, 1'b1, 64'd0});
    vecs.push_back('{1'b1, 1'b0, 64'd8,   64'd0, 1'b0, init_val(1)});
    vecs.push_back('{1'b1, 1'b0, 64'd16,  64'd0, 1'b0, 64'h1234_5678_9ABC_DEF0});
    vecs.push_back('{1'b1, 1'b1, 64'd0,   64'h5555, 1'b1, 64'd0});
    vecs.push_back('{1'b1, 1'b0, 64'd0,   64'd0, 1'b0, init_val(0)});
    vecs.push_back('{1'b0, 1'b1, 64'd504, 64'hCAFE, 1'b0, 64'd0});
    vecs.push_back('{1'b1, 1'b0, 64'd504, 64'd0, 1'b0, 64'hCAFE});
    vecs.push_back('{1'b1, 1'b0, 64'd512, 64'd0, 1'b1, 64'd0});
    vecs.push_back('{1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd0, 1'b1, 64'd0});
    vecs.push_back('{1'b1, 1'b0, 64'd24,  64'd0, 1'b0, 64'h777});

    #12;
    check64("reset Read_data", Read_data, 64'd0);
    check1("reset mem_ready", mem_ready, 1'b0);
    check1("reset mem_stall", mem_stall, 1'b0);
    check1("reset mem_err", mem_err, 1'b0);
    check_int("reset state", int'(dbg_state), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Preload the whole array through the port so every word is known.
    for (int i = 0; i < DEPTH; i++) run_op(1'b0, 1'b1, 64'(i * 8), init_val(i), -1, 64'd0, "preload");

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, -1, 64'd0,
             vecs[i].exp_err, vecs[i].exp_rdata, $sformatf("vec%0d", i));
      if (model_legal(vecs[i].rd, vecs[i].wr, vecs[i].addr) && vecs[i].wr)
        model_mem[vecs[i].addr / 8] = vecs[i].data;
    end

    // Reset in the middle of a store: store is dropped, outputs clear.
    run_op(1'b1, 1'b0, 64'd0, 64'd0, -1, 64'd0, "pre_reset_load");
    mem_write  = 1'b1;
    mem_addr   = 64'd8;
    write_data = 64'hDEAD;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset     = 1'b0;
    mem_write = 1'b0;
    #1;
    check64("midbusy_reset Read_data", Read_data, 64'd0);
    check1("midbusy_reset mem_ready", mem_ready, 1'b0);
    check1("midbusy_reset mem_stall", mem_stall, 1'b0);
    check_int("midbusy_reset state", int'(dbg_state), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    run_op(1'b1, 1'b0, 64'd8, 64'd0, -1, 64'd0, "after_reset_load8");

    // Inputs moved during BUSY are ignored.
    run_op(1'b1, 1'b0, 64'd24, 64'd0, 1, 64'd32, "load24_moved");
    run_op(1'b0, 1'b1, 64'd40, 64'hBEEF, 2, 64'd48, "store40_moved");
    run_op(1'b1, 1'b0, 64'd40, 64'd0, -1, 64'd0, "load40");
    run_op(1'b1, 1'b0, 64'd48, 64'd0, -1, 64'd0, "load48");

`ifdef DMEM_SIZE_EN
    // Sub-word store and sign/zero-extended loads.
    mem_size = 3'd0;
    do_req(1'b0, 1'b1, 64'd3, 64'h80, -1, 64'd0, 1'b0, 64'd0, "sb_addr3");
    model_mem[0][31:24] = 8'h80;
    do_req(1'b1, 1'b0, 64'd3, 64'd0, -1, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, "lb_addr3");
    mem_size = 3'd4;
    do_req(1'b1, 1'b0, 64'd3, 64'd0, -1, 64'd0, 1'b0, 64'h80, "lbu_addr3");
    mem_size = 3'd3;
`endif

    // Randomized traffic checked against the reference model.
    for (int n = 0; n < 200; n++) begin
      int          kind;
      int          word;
      int          chg;
      logic [63:0] addr;
      logic [63:0] data;
      logic        rd;
      logic        wr;
      kind = int'($urandom_range(0, 9));
      word = int'($urandom_range(0, DEPTH - 1));
      data = {$urandom, $urandom};
      addr = 64'(word * 8);
      rd   = 1'b1;
      wr   = 1'b0;
      case (kind)
        0, 1, 2, 3: ;
        4, 5, 6: begin rd = 1'b0; wr = 1'b1; end
        7: begin
          addr = addr + 64'($urandom_range(1, 7));
          rd   = $urandom_range(0, 1) == 1;
          wr   = !rd;
        end
        8: wr = 1'b1;
        default: addr = ($urandom_range(0, 1) == 1) ? (64'(DEPTH * 8) + addr)
                                                     : {$urandom, 32'd0} | 64'h8000_0000_0000_0000;
      endcase
      chg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LAT)) : -1;
      run_op(rd, wr, addr, data, chg, 64'($urandom_range(0, DEPTH - 1) * 8), $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
